// File: rtl/psg_ecfs_lvdcdc_sd_adc_trip.sv
// Sigma-delta ADC protection trip for the LV DC/DC stage.
// Filters per-sample overcurrent (phase A/B), overvoltage and ADC saturation
// conditions and sequences DISABLED -> BLANK -> ARMED -> TRIPPED.
// Ports:
//   clk_adc, reset_n         : clock (shared with ADC), async active-low reset
//   sample_i_phase_a/b       : signed 13-bit phase current samples
//   sample_v_out             : signed 13-bit output voltage sample
//   sample_valid             : one-cycle strobe for new samples
//   out_of_range             : ADC saturation flag, qualified by sample_valid
//   oc_limit / ov_limit      : unsigned OC magnitude limit / signed OV limit
//   enable / fault_clear     : arm request level / clear request pulse
//   trip / pwm_enable_out    : registered state decodes
//   fault_status             : sticky cause {adc_range, ov, oc_b, oc_a}
//   state                    : current FSM state
`timescale 1ns/1ps
module psg_ecfs_lvdcdc_sd_adc_trip #(
  parameter int unsigned FILTER_COUNT  = 3,
  parameter int unsigned BLANK_SAMPLES = 16
) (
  input  logic        clk_adc,
  input  logic        reset_n,
  input  logic [12:0] sample_i_phase_a,
  input  logic [12:0] sample_i_phase_b,
  input  logic [12:0] sample_v_out,
  input  logic        sample_valid,
  input  logic        out_of_range,
  input  logic [11:0] oc_limit,
  input  logic [12:0] ov_limit,
  input  logic        enable,
  input  logic        fault_clear,
  output logic        trip,
  output logic        pwm_enable_out,
  output logic [3:0]  fault_status,
  output logic [1:0]  state
);

  localparam int unsigned SW = 13;
  localparam int unsigned CW = 4;
  localparam int unsigned BW = 8;
  localparam int unsigned NC = 4;

  localparam logic [CW-1:0] FC_MAX     = CW'(FILTER_COUNT);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_SAMPLES - 1);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'b00,
    ST_BLANK    = 2'b01,
    ST_ARMED    = 2'b10,
    ST_TRIPPED  = 2'b11
  } state_e;

  state_e               state_q, state_d;
  logic [BW-1:0]        blank_q, blank_d;
  logic [NC-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NC-1:0]        fs_q, fs_d;
  logic                 trip_q, pwm_q;

  logic [SW-1:0]        abs_a_c, abs_b_c;
  logic [NC-1:0]        cond_c;
  logic [NC-1:0]        qual_c;

  // Two's-complement magnitude; -4096 maps to 13'h1000 (4096 unsigned).
  assign abs_a_c = sample_i_phase_a[SW-1] ? (~sample_i_phase_a + SW'(1)) : sample_i_phase_a;
  assign abs_b_c = sample_i_phase_b[SW-1] ? (~sample_i_phase_b + SW'(1)) : sample_i_phase_b;

  // Raw per-sample conditions, bit order {adc_range, ov, oc_b, oc_a}.
  assign cond_c[0] = abs_a_c > {1'b0, oc_limit};
  assign cond_c[1] = abs_b_c > {1'b0, oc_limit};
  assign cond_c[2] = $signed(sample_v_out) > $signed(ov_limit);
  assign cond_c[3] = out_of_range;

  // Filter counters, blanking counter and state sequencing.
  always_comb begin
    cnt_d   = cnt_q;
    qual_c  = '0;
    state_d = state_q;
    fs_d    = fs_q;
    blank_d = '0;

    for (int i = 0; i < NC; i++) begin
      if (sample_valid) begin
        if (cond_c[i]) begin
          if (cnt_q[i] != FC_MAX) cnt_d[i] = cnt_q[i] + CW'(1);
          // Qualifies only on the sample that brings the count up to the limit.
          qual_c[i] = (cnt_q[i] == FC_MAX - CW'(1));
        end else begin
          cnt_d[i] = '0;
        end
      end
    end

    case (state_q)
      ST_DISABLED: begin
        if (enable) state_d = ST_BLANK;
      end
      ST_BLANK: begin
        if (!enable) begin
          state_d = ST_DISABLED;
        end else if (sample_valid) begin
          if (blank_q == BLANK_LAST) state_d = ST_ARMED;
          else                       blank_d = blank_q + BW'(1);
        end else begin
          blank_d = blank_q;
        end
      end
      ST_ARMED: begin
        // A fault wins over a simultaneous enable drop.
        if (|qual_c) begin
          state_d = ST_TRIPPED;
          fs_d    = qual_c;
        end else if (!enable) begin
          state_d = ST_DISABLED;
        end
      end
      ST_TRIPPED: begin
        if (fault_clear) state_d = enable ? ST_BLANK : ST_DISABLED;
      end
    endcase

    // Counters only run in ARMED/TRIPPED; any path into DISABLED/BLANK wipes them.
    if (state_q == ST_DISABLED || state_q == ST_BLANK ||
        state_d == ST_DISABLED || state_d == ST_BLANK) begin
      cnt_d = '0;
    end
    if (state_d != ST_TRIPPED) fs_d = '0;
  end

  // State and output registers.
  always_ff @(posedge clk_adc or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_DISABLED;
      blank_q <= '0;
      cnt_q   <= '0;
      fs_q    <= '0;
      trip_q  <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blank_q <= blank_d;
      cnt_q   <= cnt_d;
      fs_q    <= fs_d;
      trip_q  <= (state_d == ST_TRIPPED);
      pwm_q   <= (state_d == ST_ARMED);
    end
  end

  assign trip           = trip_q;
  assign pwm_enable_out = pwm_q;
  assign fault_status   = fs_q;
  assign state          = state_q;

endmodule

// File: doc/psg_ecfs_lvdcdc_sd_adc_trip.md
PSG_ECFS_LVDCDC_SD_ADC_TRIP -- requirements
Module: psg_ecfs_lvdcdc_sd_adc_trip

Interface
REQ-001 SHALL have parameter FILTER_COUNT, default 3: consecutive out-of-limit samples needed to qualify a fault (range 1..15).
REQ-002 SHALL have parameter BLANK_SAMPLES, default 16: sample_valid pulses ignored after arming (range 1..255).
REQ-003 SHALL have port clk_adc, input, 1: sole clock, shared with the sigma-delta ADC block.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have ports sample_i_phase_a, sample_i_phase_b, sample_v_out, input, 13 each: signed scaled samples from the ADC block.
REQ-006 SHALL have port sample_valid, input, 1: one-cycle strobe marking new samples.
REQ-007 SHALL have port out_of_range, input, 1: ADC saturation flag, valid with sample_valid.
REQ-008 SHALL have port oc_limit, input, 12: unsigned overcurrent magnitude limit.
REQ-009 SHALL have port ov_limit, input, 13: signed overvoltage limit.
REQ-010 SHALL have port enable, input, 1: level request to arm protection.
REQ-011 SHALL have port fault_clear, input, 1: single-cycle clear request.
REQ-012 SHALL have port trip, output, 1: registered, high while in TRIPPED.
REQ-013 SHALL have port pwm_enable_out, output, 1: registered, high only in ARMED.
REQ-014 SHALL have port fault_status, output, 4: sticky cause {adc_range, ov, oc_b, oc_a} (bits 3..0).
REQ-015 SHALL have port state, output, 2: current FSM state encoding.

Function
REQ-016 SHALL evaluate inputs only in cycles where sample_valid=1; all other cycles leave counters unchanged.
REQ-017 SHALL compute |x| of each current sample as 13-bit unsigned, -4096 mapping to 4096; oc_x condition = |x| > {1'b0,oc_limit}.
REQ-018 SHALL set ov condition = signed sample_v_out > signed ov_limit; adc_range condition = out_of_range.
REQ-019 SHALL keep one 4-bit counter per condition: on a valid sample, +1 if condition true (saturating at FILTER_COUNT), else cleared to 0.
REQ-020 SHALL qualify a condition in the cycle its counter becomes equal to FILTER_COUNT (FILTER_COUNT=1 => first offending sample).
REQ-021 SHALL implement states DISABLED=00, BLANK=01, ARMED=10, TRIPPED=11.
REQ-022 DISABLED: enable=1 -> BLANK; counters held 0.
REQ-023 BLANK: count sample_valid pulses; after BLANK_SAMPLES pulses -> ARMED; counters held 0; enable=0 -> DISABLED.
REQ-024 ARMED: any qualified condition -> TRIPPED; enable=0 -> DISABLED; fault takes priority over enable=0 in the same cycle.
REQ-025 On ARMED->TRIPPED, fault_status SHALL load every condition qualifying in that cycle (multiple bits allowed).
REQ-026 TRIPPED: stays regardless of enable; fault_clear=1 -> BLANK if enable=1, else DISABLED; fault_status and counters cleared on exit.
REQ-027 fault_clear outside TRIPPED SHALL be ignored.
REQ-028 trip and pwm_enable_out SHALL update one clk_adc cycle after the sample_valid cycle that qualifies the fault (registered state decode).
REQ-029 Counters SHALL continue updating in TRIPPED but SHALL NOT alter fault_status.

Reset
REQ-030 On reset_n=0, asynchronously: state=DISABLED, trip=0, pwm_enable_out=0, fault_status=0, all counters and blank counter=0.
REQ-031 Reset asserted mid-operation (including TRIPPED) SHALL discard all history; after release, arming requires the full BLANK sequence.

Verification
REQ-032 enable=1, 16 valid strobes with zero samples -> state BLANK then ARMED, pwm_enable_out=1 on cycle after 16th strobe.
REQ-033 ARMED, oc_limit=2000, sample_i_phase_a=2001 for 3 strobes -> trip=1 one cycle after 3rd strobe, fault_status=4'b0001; 2 strobes then 0 -> no trip.
REQ-034 ARMED, sample_i_phase_b=-4096, oc_limit=4095, sample_v_out=1000 > ov_limit=900, 3 strobes -> fault_status=4'b0110.
REQ-035 TRIPPED, enable=0 then fault_clear pulse -> DISABLED, fault_status=0; with enable=1 -> BLANK, pwm_enable_out=0 until 16 strobes.
REQ-036 ARMED with out_of_range=1 for 3 strobes and enable dropped in qualifying cycle -> TRIPPED, fault_status=4'b1000.
REQ-037 reset_n pulsed low while TRIPPED -> all outputs 0 immediately, state=DISABLED.
